// File: rtl/gpu_frame_sequencer.sv
// Frame-level scheduler for voxel_gpu: walks the frame strip by strip, issuing GPU CSR commands
// (strip setup, rasterize per voxel, shade per palette entry, write-out per pixel) and acking each GPU interrupt.
module gpu_frame_sequencer #(
  parameter int unsigned H_RESOLUTION = 320,
  parameter int unsigned V_RESOLUTION = 240,
  parameter int unsigned NUM_SHADERS  = 320,
  parameter int unsigned TIMEOUT      = 2**20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  c_address,
  input  logic        c_read,
  input  logic        c_write,
  input  logic [31:0] c_writedata,
  output logic [31:0] c_readdata,
  output logic        irq,
  output logic [7:0]  g_address,
  output logic        g_write,
  output logic        g_read,
  output logic [31:0] g_writedata,
  input  logic [31:0] g_readdata,
  input  logic        g_irq,
  output logic [31:0] m_address,
  output logic        m_read,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  input  logic        m_readdatavalid
);

  localparam int unsigned COL_BITS  = $clog2(H_RESOLUTION);
  localparam int unsigned ROW_BITS  = $clog2(V_RESOLUTION);
  localparam int unsigned TOTAL_PIX = H_RESOLUTION * V_RESOLUTION;
  localparam int unsigned NSTRIPS   = (TOTAL_PIX + NUM_SHADERS - 1) / NUM_SHADERS;
  localparam int unsigned TMO_BITS  = $clog2(TIMEOUT + 1);

  localparam logic [7:0] GA_VOXEL  = 8'h00;
  localparam logic [7:0] GA_PAL    = 8'h01;
  localparam logic [7:0] GA_PIXEL  = 8'h02;
  localparam logic [7:0] GA_STRIP  = 8'h03;
  localparam logic [7:0] GA_STATUS = 8'h0f;

  typedef enum logic [3:0] {
    S_IDLE, S_STRIP, S_WAIT, S_ACK, S_VOX_FETCH, S_VOX_CMD, S_PAL_FETCH,
    S_PAL_CMD, S_PIX_CMD, S_NEXT, S_DONE, S_RECOVER
  } state_t;

  // Which command the current WAIT/ACK pair belongs to.
  typedef enum logic [1:0] {PH_STRIP, PH_VOX, PH_PAL, PH_PIX} phase_t;

  state_t state, state_n;
  phase_t phase;

  logic [31:0] vox_base, vox_count, pal_base, pal_count, fb_base;
  logic [31:0] strip_idx, start_pixel, item_idx, cur_pix, fetch_word;
  logic [COL_BITS-1:0] cur_col;
  logic [ROW_BITS-1:0] cur_row;
  logic [TMO_BITS-1:0] wait_cnt;
  logic fetch_issued, done_flag, error_flag;

  logic busy, ctrl_wr, start_req, abort_req, status_rd;
  logic set_done, set_error, in_fetch, fetch_done, ack_pass, same_phase;
  logic has_vox, has_pal, more_vox, more_pal, more_pix;
  logic [31:0] pix_addr;

  assign busy      = (state != S_IDLE);
  assign ctrl_wr   = c_write && (c_address == 3'd0);
  assign abort_req = ctrl_wr && c_writedata[1];
  assign start_req = ctrl_wr && c_writedata[0] && !c_writedata[1];
  assign status_rd = c_read && (c_address == 3'd1);

  assign has_vox  = (vox_count != 32'd0);
  assign has_pal  = (pal_count != 32'd0);
  assign more_vox = (item_idx + 32'd1) < vox_count;
  assign more_pal = (item_idx + 32'd1) < pal_count;
  assign more_pix = ((item_idx + 32'd1) < NUM_SHADERS) && ((cur_pix + 32'd1) < TOTAL_PIX);

  assign in_fetch   = (state == S_VOX_FETCH) || (state == S_PAL_FETCH);
  assign fetch_done = in_fetch && fetch_issued && m_readdatavalid;
  assign ack_pass   = (state == S_ACK) && (state_n != S_RECOVER);
  assign same_phase = ((phase == PH_VOX) && (state_n == S_VOX_FETCH)) ||
                      ((phase == PH_PAL) && (state_n == S_PAL_FETCH)) ||
                      ((phase == PH_PIX) && (state_n == S_PIX_CMD));

  assign pix_addr = fb_base | (32'(cur_row) << (COL_BITS + 1)) | (32'(cur_col) << 1);

  always_comb begin
    state_n     = state;
    g_address   = 8'h00;
    g_write     = 1'b0;
    g_read      = 1'b0;
    g_writedata = 32'd0;
    m_read      = 1'b0;
    m_address   = 32'd0;
    set_error   = 1'b0;
    case (state)
      S_IDLE: if (start_req) state_n = S_STRIP;
      S_STRIP: begin
        g_write     = 1'b1;
        g_address   = GA_STRIP;
        g_writedata = start_pixel;
        state_n     = S_WAIT;
      end
      S_WAIT: begin
        // The GPU status register may only be read once it has interrupted.
        if (g_irq) state_n = S_ACK;
        else if (wait_cnt == TMO_BITS'(TIMEOUT - 1)) state_n = S_RECOVER;
      end
      S_ACK: begin
        g_read    = 1'b1;
        g_address = GA_STATUS;
        if (g_readdata != 32'd0) state_n = S_RECOVER;
        else begin
          case (phase)
            PH_STRIP: state_n = has_vox ? S_VOX_FETCH : (has_pal ? S_PAL_FETCH : S_PIX_CMD);
            PH_VOX:   state_n = more_vox ? S_VOX_FETCH : (has_pal ? S_PAL_FETCH : S_PIX_CMD);
            PH_PAL:   state_n = more_pal ? S_PAL_FETCH : S_PIX_CMD;
            default:  state_n = more_pix ? S_PIX_CMD : S_NEXT;
          endcase
        end
      end
      S_VOX_FETCH: begin
        m_read    = !fetch_issued;
        m_address = vox_base + (item_idx << 2);
        if (fetch_done) state_n = S_VOX_CMD;
      end
      S_VOX_CMD: begin
        g_write     = 1'b1;
        g_address   = GA_VOXEL;
        g_writedata = fetch_word;
        state_n     = S_WAIT;
      end
      S_PAL_FETCH: begin
        m_read    = !fetch_issued;
        m_address = pal_base + (item_idx << 2);
        if (fetch_done) state_n = S_PAL_CMD;
      end
      S_PAL_CMD: begin
        g_write     = 1'b1;
        g_address   = GA_PAL;
        g_writedata = fetch_word;
        state_n     = S_WAIT;
      end
      S_PIX_CMD: begin
        g_write     = 1'b1;
        g_address   = GA_PIXEL;
        g_writedata = pix_addr;
        state_n     = S_WAIT;
      end
      S_NEXT: state_n = ((strip_idx + 32'd1) < NSTRIPS) ? S_STRIP : S_DONE;
      S_DONE: state_n = S_IDLE;
      S_RECOVER: begin
        g_write     = 1'b1;
        g_address   = GA_STATUS;
        g_writedata = 32'd1;
        set_error   = 1'b1;
        state_n     = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (abort_req && (state != S_IDLE) && (state != S_RECOVER)) state_n = S_RECOVER;
  end

  assign set_done = (state == S_DONE) && (state_n == S_IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      phase        <= PH_STRIP;
      strip_idx    <= 32'd0;
      start_pixel  <= 32'd0;
      item_idx     <= 32'd0;
      cur_pix      <= 32'd0;
      cur_col      <= '0;
      cur_row      <= '0;
      wait_cnt     <= '0;
      fetch_issued <= 1'b0;
      fetch_word   <= 32'd0;
    end else begin
      state <= state_n;
      if (state == S_WAIT) wait_cnt <= wait_cnt + TMO_BITS'(1);
      else wait_cnt <= '0;

      // A fetch request stays up until accepted; any state change drops the tracking.
      if (state_n != state) fetch_issued <= 1'b0;
      else if (in_fetch && !fetch_issued && !m_waitrequest) fetch_issued <= 1'b1;
      if (fetch_done) fetch_word <= m_readdata;

      case (state)
        S_STRIP:   phase <= PH_STRIP;
        S_VOX_CMD: phase <= PH_VOX;
        S_PAL_CMD: phase <= PH_PAL;
        S_PIX_CMD: phase <= PH_PIX;
        default:   ;
      endcase

      if ((state == S_IDLE) && (state_n == S_STRIP)) begin
        strip_idx   <= 32'd0;
        start_pixel <= 32'd0;
        cur_pix     <= 32'd0;
        cur_col     <= '0;
        cur_row     <= '0;
      end

      if (ack_pass) item_idx <= same_phase ? item_idx + 32'd1 : 32'd0;

      // Row/column follow the pixel index incrementally, including across strip boundaries.
      if (ack_pass && (phase == PH_PIX)) begin
        cur_pix <= cur_pix + 32'd1;
        if (cur_col == COL_BITS'(H_RESOLUTION - 1)) begin
          cur_col <= '0;
          cur_row <= cur_row + ROW_BITS'(1);
        end else begin
          cur_col <= cur_col + COL_BITS'(1);
        end
      end

      if ((state == S_NEXT) && (state_n == S_STRIP)) begin
        strip_idx   <= strip_idx + 32'd1;
        start_pixel <= start_pixel + NUM_SHADERS;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vox_base   <= 32'd0;
      vox_count  <= 32'd0;
      pal_base   <= 32'd0;
      pal_count  <= 32'd0;
      fb_base    <= 32'd0;
      done_flag  <= 1'b0;
      error_flag <= 1'b0;
    end else begin
      if (c_write && !busy) begin
        case (c_address)
          3'd2: vox_base  <= c_writedata;
          3'd3: vox_count <= c_writedata;
          3'd4: pal_base  <= c_writedata;
          3'd5: pal_count <= c_writedata;
          3'd6: fb_base   <= c_writedata;
          default: ;
        endcase
      end
      // A flag raised in the same cycle as a STATUS read survives until the next read.
      if (set_done) done_flag <= 1'b1;
      else if (status_rd) done_flag <= 1'b0;
      if (set_error) error_flag <= 1'b1;
      else if (status_rd) error_flag <= 1'b0;
    end
  end

  always_comb begin
    c_readdata = 32'd0;
    case (c_address)
      3'd1: c_readdata = {29'd0, error_flag | set_error, done_flag | set_done, busy};
      3'd2: c_readdata = vox_base;
      3'd3: c_readdata = vox_count;
      3'd4: c_readdata = pal_base;
      3'd5: c_readdata = pal_count;
      3'd6: c_readdata = fb_base;
      3'd7: c_readdata = strip_idx;
      default: c_readdata = 32'd0;
    endcase
  end

  assign irq = done_flag | error_flag;

endmodule

// File: tb/tb_gpu_frame_sequencer.sv
// Bench for gpu_frame_sequencer: host CSR driver, GPU slave model with scoreboard of expected
// GPU transactions, and a memory model with configurable wait states and read latency.
module tb_gpu_frame_sequencer;
  localparam int H   = 10;
  localparam int V   = 2;
  localparam int NS  = 8;
  localparam int TMO = 16;
  localparam int EW  = 41;

  logic        clock, reset;
  logic [2:0]  c_address;
  logic        c_read, c_write;
  logic [31:0] c_writedata, c_readdata;
  logic        irq;
  logic [7:0]  g_address;
  logic        g_write, g_read;
  logic [31:0] g_writedata, g_readdata;
  logic        g_irq;
  logic [31:0] m_address;
  logic        m_read, m_waitrequest;
  logic [31:0] m_readdata;
  logic        m_readdatavalid;

  int total = 0;
  int bad = 0;
  logic [EW-1:0] exp_q[$];

  int cmd_num, err_cmd, irq_delay, irq_cnt, cyc, cmd_cyc, rec_cyc;
  bit irq_pending, withhold;
  int mem_ws, mem_lat, ws_left, lat_left, mem_reads;
  bit rd_pending, accepting;
  logic [31:0] acc_addr, rd_addr;

  gpu_frame_sequencer #(
    .H_RESOLUTION(H), .V_RESOLUTION(V), .NUM_SHADERS(NS), .TIMEOUT(TMO)
  ) dut (
    .clock(clock), .reset(reset),
    .c_address(c_address), .c_read(c_read), .c_write(c_write),
    .c_writedata(c_writedata), .c_readdata(c_readdata), .irq(irq),
    .g_address(g_address), .g_write(g_write), .g_read(g_read),
    .g_writedata(g_writedata), .g_readdata(g_readdata), .g_irq(g_irq),
    .m_address(m_address), .m_read(m_read), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  function automatic logic [EW-1:0] mk(input logic rd, input logic [7:0] a, input logic [31:0] d);
    return {rd, a, d};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clock);
    c_address = a; c_writedata = d; c_write = 1'b1;
    @(negedge clock);
    c_write = 1'b0;
  endtask

  task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clock);
    c_address = a; c_read = 1'b1;
    #1 d = c_readdata;
    @(negedge clock);
    c_read = 1'b0;
  endtask

  task automatic wait_irq(input int budget);
    int n = 0;
    while (!irq && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("irq_wait", 64'(irq), 64'd1);
  endtask

  task automatic push_cmd(input logic [7:0] a, input logic [31:0] d);
    exp_q.push_back(mk(1'b0, a, d));
    exp_q.push_back(mk(1'b1, 8'h0f, 32'h0));
  endtask

  task automatic push_recover();
    exp_q.push_back(mk(1'b0, 8'h0f, 32'h1));
  endtask

  // H=10: COL_BITS=4, so the row lands at bit 5 and the column at bit 1.
  task automatic expect_frame(input int vc, input int pc, input logic [31:0] fb);
    for (int s = 0; s < 3; s++) begin
      push_cmd(8'h03, 32'(s * NS));
      for (int i = 0; i < vc; i++) push_cmd(8'h00, memf(32'h100 + 32'(4 * i)));
      for (int i = 0; i < pc; i++) push_cmd(8'h01, memf(32'h200 + 32'(4 * i)));
      for (int j = 0; j < NS; j++) begin
        int p = s * NS + j;
        if (p < H * V) push_cmd(8'h02, fb | 32'((p / H) << 5) | 32'((p % H) << 1));
      end
    end
  endtask

  task automatic new_scenario(input int err, input bit hold, input int ws, input int lat);
    cmd_num = 0; err_cmd = err; withhold = hold;
    mem_ws = ws; mem_lat = lat; ws_left = ws; mem_reads = 0;
  endtask

  // GPU slave model and scoreboard monitor
  initial begin
    logic [EW-1:0] act;
    g_irq = 1'b0; g_readdata = 32'd0; cyc = 0; irq_pending = 0; irq_cnt = 0;
    cmd_cyc = 0; rec_cyc = 0;
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset) begin
        if (g_write || g_read || m_read)
          check("bus_exclusive", 64'(32'(g_write) + 32'(g_read) + 32'(m_read)), 64'd1);
        if (g_write || g_read) begin
          act = {g_read, g_address, g_read ? 32'h0 : g_writedata};
          if (exp_q.size() == 0) check("sb_unexpected", 64'(act), 64'(~act));
          else check("gpu_txn", 64'(act), 64'(exp_q.pop_front()));
          if (g_read) check("ack_after_irq", 64'(g_irq), 64'd1);
        end
        if (g_write && g_address <= 8'h03) begin
          cmd_num++;
          cmd_cyc = cyc;
          if (!withhold) begin
            irq_pending = 1;
            irq_cnt = irq_delay;
          end
        end
        if (g_write && g_address == 8'h0f) rec_cyc = cyc;
        if (g_read) g_irq = 1'b0;
        else if (irq_pending) begin
          if (irq_cnt == 0) begin
            g_irq = 1'b1;
            g_readdata = (cmd_num == err_cmd) ? 32'd2 : 32'd0;
            irq_pending = 0;
          end else irq_cnt--;
        end
      end
    end
  end

  // memory model: ws_left stall cycles per request, then data mem_lat cycles after accept
  initial begin
    m_waitrequest = 1'b1; m_readdatavalid = 1'b0; m_readdata = 32'd0;
    rd_pending = 0; accepting = 0; lat_left = 0; acc_addr = 32'd0; rd_addr = 32'd0;
    forever begin
      @(negedge clock);
      m_readdatavalid = 1'b0;
      if (accepting) begin
        accepting = 0;
        mem_reads++;
        check("m_read_dropped", 64'(m_read), 64'd0);
        rd_addr = acc_addr;
        rd_pending = 1;
        lat_left = mem_lat;
        m_waitrequest = 1'b1;
        ws_left = mem_ws;
      end else if (rd_pending) begin
        if (lat_left <= 1) begin
          m_readdatavalid = 1'b1;
          m_readdata = memf(rd_addr);
          rd_pending = 0;
        end else lat_left--;
      end else if (m_read) begin
        if (ws_left > 0) begin
          m_waitrequest = 1'b1;
          ws_left--;
        end else begin
          m_waitrequest = 1'b0;
          accepting = 1;
          acc_addr = m_address;
        end
      end
    end
  end

  // stimulus
  initial begin
    logic [31:0] d;
    int n;
    reset = 1'b1; c_address = 3'd0; c_read = 1'b0; c_write = 1'b0; c_writedata = 32'd0;
    irq_delay = 1;
    new_scenario(0, 0, 0, 1);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_irq", 64'(irq), 64'd0);
    check("rst_g_write", 64'(g_write), 64'd0);
    check("rst_m_read", 64'(m_read), 64'd0);
    csr_read(3'd1, d); check("rst_status", 64'(d), 64'd0);
    csr_read(3'd7, d); check("rst_strip", 64'(d), 64'd0);
    csr_read(3'd3, d); check("rst_vox_count", 64'(d), 64'd0);

    // full frame: 2 voxels, 1 palette entry, 3 strips of 8/8/4 pixels
    csr_write(3'd2, 32'h100); csr_write(3'd3, 32'd2);
    csr_write(3'd4, 32'h200); csr_write(3'd5, 32'd1);
    csr_write(3'd6, 32'h1000);
    new_scenario(0, 0, 0, 1);
    expect_frame(2, 1, 32'h1000);
    csr_write(3'd0, 32'd1);
    csr_write(3'd3, 32'd5);
    wait_irq(5000);
    csr_read(3'd1, d); check("frame_status", 64'(d), 64'h2);
    csr_read(3'd1, d); check("frame_status_clr", 64'(d), 64'h0);
    check("frame_irq_clr", 64'(irq), 64'd0);
    csr_read(3'd3, d); check("busy_write_ignored", 64'(d), 64'd2);
    csr_read(3'd7, d); check("last_strip", 64'(d), 64'd2);
    check("frame_mem_reads", 64'(mem_reads), 64'd9);
    check("frame_sb_empty", 64'(exp_q.size()), 64'd0);

    // GPU reports an error on the second voxel
    new_scenario(3, 0, 0, 1);
    push_cmd(8'h03, 32'd0);
    push_cmd(8'h00, memf(32'h100));
    push_cmd(8'h00, memf(32'h104));
    push_recover();
    csr_write(3'd0, 32'd1);
    wait_irq(2000);
    repeat (20) @(negedge clock);
    csr_read(3'd1, d); check("err_status", 64'(d), 64'h4);
    csr_read(3'd1, d); check("err_status_clr", 64'(d), 64'h0);
    check("err_sb_empty", 64'(exp_q.size()), 64'd0);

    // GPU never interrupts: timeout after 16 cycles in WAIT
    new_scenario(0, 1, 0, 1);
    push_cmd(8'h03, 32'd0);
    void'(exp_q.pop_back());
    push_recover();
    csr_write(3'd0, 32'd1);
    wait_irq(200);
    check("timeout_gap", 64'(rec_cyc - cmd_cyc), 64'd17);
    csr_read(3'd1, d); check("timeout_status", 64'(d), 64'h4);
    check("timeout_sb_empty", 64'(exp_q.size()), 64'd0);

    // abort together with start while waiting: abort wins
    new_scenario(0, 1, 0, 1);
    exp_q.push_back(mk(1'b0, 8'h03, 32'd0));
    push_recover();
    csr_write(3'd0, 32'd1);
    n = 0;
    while (cmd_num < 1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("abort_cmd_seen", 64'(cmd_num), 64'd1);
    csr_write(3'd0, 32'd3);
    wait_irq(10);
    repeat (5) @(negedge clock);
    csr_read(3'd1, d); check("abort_status", 64'(d), 64'h4);
    csr_read(3'd1, d); check("abort_idle", 64'(d), 64'h0);
    check("abort_sb_empty", 64'(exp_q.size()), 64'd0);

    // memory stalls 5 cycles and returns data 3 cycles after accept; no palette
    csr_write(3'd3, 32'd1); csr_write(3'd5, 32'd0);
    new_scenario(0, 0, 5, 3);
    expect_frame(1, 0, 32'h1000);
    csr_write(3'd0, 32'd1);
    wait_irq(5000);
    csr_read(3'd1, d); check("ws_status", 64'(d), 64'h2);
    check("ws_mem_reads", 64'(mem_reads), 64'd3);
    check("ws_sb_empty", 64'(exp_q.size()), 64'd0);

    // no voxels and no palette: strips go straight to pixel write-out
    csr_write(3'd3, 32'd0); csr_write(3'd6, 32'h8000);
    new_scenario(0, 0, 0, 1);
    expect_frame(0, 0, 32'h8000);
    csr_write(3'd0, 32'd1);
    wait_irq(5000);
    csr_read(3'd1, d); check("skip_status", 64'(d), 64'h2);
    check("skip_mem_reads", 64'(mem_reads), 64'd0);
    check("skip_sb_empty", 64'(exp_q.size()), 64'd0);

    repeat (5) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
